// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Execute-stage issue controller for the ALU and its multi-cycle multiplier.
// Takes one decoded instruction at a time over a valid/ready handshake,
// translates the OPCODE_* encoding into the matching ALUOP_* code, and issues
// it with a one-cycle ex_start pulse. A MUL holds decode off for MUL_LATENCY
// cycles, and its destination register is exported for hazard detection.
//
// Parameters:
//   MUL_LATENCY  cycles the multiplier is occupied per MUL (>= 1)
//   REG_ADDR_W   destination register index width
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   dec_valid     decode presents an instruction
//   dec_opcode    OPCODE_* encoding
//   dec_rd        destination register
//   dec_ready     controller can accept this cycle
//   flush         squash the in-flight op (branch/exception)
//   ex_start      one-cycle pulse: aluop/ex_rd valid, ALU/multiplier starts
//   ex_done       one-cycle pulse: result valid for writeback
//   aluop         ALUOP_* to the ALU, held until the next issue
//   ex_rd         destination of the issued op, held
//   ex_sel_mul    result mux selects multiplier, held
//   busy          multiplier occupied
//   hazard_rd     destination of the pending MUL
//   hazard_valid  hazard_rd is meaningful
//   illegal_op    (only with ALU_ISSUE_ILLEGAL_EN) one-cycle pulse when an
//                 unknown opcode is consumed
//
// Optional feature macro: ALU_ISSUE_ILLEGAL_EN
//   Defined:   adds illegal_op and raises `WARNING for unknown opcodes.
//   Undefined: unknown opcodes are silently consumed as a NOP.
// ---------------------------------------------------------------------------

`ifndef WARNING
`define WARNING(val)
`endif

module alu_issue_ctrl #(
  parameter int MUL_LATENCY = 5,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [7:0]            dec_opcode,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  dec_ready,
  input  logic                  flush,
  output logic                  ex_start,
  output logic                  ex_done,
  output logic [7:0]            aluop,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_sel_mul,
  output logic                  busy,
  output logic [REG_ADDR_W-1:0] hazard_rd,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic                  hazard_valid,
  output logic                  illegal_op
`else
  output logic                  hazard_valid
`endif
);

  // Decode-side opcode encodings
  localparam logic [7:0] OPCODE_ADD      = 8'h01;
  localparam logic [7:0] OPCODE_SUB      = 8'h02;
  localparam logic [7:0] OPCODE_MUL      = 8'h03;
  localparam logic [7:0] OPCODE_LDB      = 8'h04;
  localparam logic [7:0] OPCODE_LDW      = 8'h05;
  localparam logic [7:0] OPCODE_STB      = 8'h06;
  localparam logic [7:0] OPCODE_STW      = 8'h07;
  localparam logic [7:0] OPCODE_MOV      = 8'h08;
  localparam logic [7:0] OPCODE_BEQ      = 8'h09;
  localparam logic [7:0] OPCODE_JUMP     = 8'h0A;
  localparam logic [7:0] OPCODE_TLBWRITE = 8'h0B;
  localparam logic [7:0] OPCODE_IRET     = 8'h0C;

  // ALU-side operation encodings
  localparam logic [7:0] ALUOP_ADD      = 8'h10;
  localparam logic [7:0] ALUOP_SUB      = 8'h11;
  localparam logic [7:0] ALUOP_MUL      = 8'h12;
  localparam logic [7:0] ALUOP_LDB      = 8'h13;
  localparam logic [7:0] ALUOP_LDW      = 8'h14;
  localparam logic [7:0] ALUOP_STB      = 8'h15;
  localparam logic [7:0] ALUOP_STW      = 8'h16;
  localparam logic [7:0] ALUOP_MOV      = 8'h17;
  localparam logic [7:0] ALUOP_BEQ      = 8'h18;
  localparam logic [7:0] ALUOP_JUMP     = 8'h19;
  localparam logic [7:0] ALUOP_TLBWRITE = 8'h1A;
  localparam logic [7:0] ALUOP_IRET     = 8'h1B;

  localparam int               CNT_W     = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // A single-cycle multiplier behaves exactly like a plain ALU op
  localparam bit               MUL_MULTI = (MUL_LATENCY > 1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       accept;
  logic       op_known;
  logic       op_is_mul;
  logic [7:0] op_aluop;

  // Fixed opcode translation table
  always_comb begin
    op_known  = 1'b1;
    op_is_mul = 1'b0;
    op_aluop  = 8'h00;
    case (dec_opcode)
      OPCODE_ADD:      op_aluop = ALUOP_ADD;
      OPCODE_SUB:      op_aluop = ALUOP_SUB;
      OPCODE_MUL: begin
        op_aluop  = ALUOP_MUL;
        op_is_mul = 1'b1;
      end
      OPCODE_LDB:      op_aluop = ALUOP_LDB;
      OPCODE_LDW:      op_aluop = ALUOP_LDW;
      OPCODE_STB:      op_aluop = ALUOP_STB;
      OPCODE_STW:      op_aluop = ALUOP_STW;
      OPCODE_MOV:      op_aluop = ALUOP_MOV;
      OPCODE_BEQ:      op_aluop = ALUOP_BEQ;
      OPCODE_JUMP:     op_aluop = ALUOP_JUMP;
      OPCODE_TLBWRITE: op_aluop = ALUOP_TLBWRITE;
      OPCODE_IRET:     op_aluop = ALUOP_IRET;
      default:         op_known = 1'b0;
    endcase
  end

  // While the multiplier is busy, decode may only hand over a new op in the
  // final cycle (cnt==0), so the next op issues right after the MUL retires.
  always_comb begin
    if (state == IDLE) dec_ready = !flush;
    else               dec_ready = (cnt == '0) && !flush;
  end

  assign accept = dec_valid && dec_ready;

  // Issue FSM. ex_done for a multi-cycle MUL is registered one cycle ahead,
  // i.e. set on the edge where cnt goes 1->0, so it lines up with cnt==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ex_start     <= 1'b0;
      ex_done      <= 1'b0;
      aluop        <= 8'h00;
      ex_rd        <= '0;
      ex_sel_mul   <= 1'b0;
      busy         <= 1'b0;
      hazard_rd    <= '0;
      hazard_valid <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_op   <= 1'b0;
`endif
    end else begin
      ex_start <= 1'b0;
      ex_done  <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      illegal_op <= 1'b0;
`endif
      if (flush) begin
        // Squash whatever is pending; held issue outputs stay as they were
        state        <= IDLE;
        cnt          <= '0;
        busy         <= 1'b0;
        hazard_valid <= 1'b0;
      end else begin
        if (state == MUL_BUSY && cnt != '0) begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) ex_done <= 1'b1;
        end else if (state == MUL_BUSY) begin
          // Final multiplier cycle: retire unless a new MUL overrides below
          state        <= IDLE;
          busy         <= 1'b0;
          hazard_valid <= 1'b0;
        end

        if (accept) begin
          if (op_known) begin
            ex_start   <= 1'b1;
            aluop      <= op_aluop;
            ex_rd      <= dec_rd;
            ex_sel_mul <= op_is_mul;
            if (op_is_mul && MUL_MULTI) begin
              state        <= MUL_BUSY;
              cnt          <= CNT_INIT;
              busy         <= 1'b1;
              hazard_valid <= 1'b1;
              hazard_rd    <= dec_rd;
            end else begin
              ex_done <= 1'b1;
            end
          end else begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            illegal_op <= 1'b1;
            `WARNING(dec_opcode);
`endif
          end
        end
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Execute-stage issue controller for the ALU and its multi-cycle multiplier.
- Accepts one decoded instruction at a time from decode via a valid/ready handshake.
- Translates each OPCODE_* (define.v) into the matching ALUOP_* and issues it to the ALU.
- Holds decode off while a MUL occupies the multiplier, and exports the pending MUL destination register for hazard detection.

Parameters:
MUL_LATENCY, 5, cycles the multiplier is occupied per MUL (legal range ≥1)
REG_ADDR_W, 5, destination register index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dec_valid  in  1  decode presents an instruction
dec_opcode  in  8  OPCODE_* encoding
dec_rd  in  REG_ADDR_W  destination register
dec_ready  out  1  controller can accept this cycle
flush  in  1  squash the in-flight op (branch/exception)
ex_start  out  1  one-cycle pulse: aluop/ex_rd valid, ALU/multiplier starts
ex_done  out  1  one-cycle pulse: result valid for writeback
aluop  out  8  ALUOP_* to the ALU, held until the next issue
ex_rd  out  REG_ADDR_W  destination of the issued op, held
ex_sel_mul  out  1  result mux selects multiplier, held
busy  out  1  multiplier occupied
hazard_rd  out  REG_ADDR_W  destination of the pending MUL
hazard_valid  out  1  hazard_rd is meaningful

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE; counter 0.
  - ex_start, ex_done, aluop, ex_rd, ex_sel_mul, busy, hazard_rd, hazard_valid all 0.
- States:
  - IDLE: dec_ready = !flush.
  - MUL_BUSY: dec_ready = (cnt==0) && !flush.
- Accept: dec_valid && dec_ready at a rising edge.
- Opcode mapping (fixed): ADD, SUB, MUL, LDB, LDW, STB, STW, MOV, BEQ, JUMP, TLBWRITE and IRET each map to the same-named ALUOP_*.
- Non-MUL accepted in cycle N:
  - Cycle N+1: ex_start=1, ex_done=1, aluop/ex_rd updated, ex_sel_mul=0.
  - State stays IDLE; back-to-back accepts every cycle.
- MUL accepted in cycle N, MUL_LATENCY=1: identical to non-MUL, except ex_sel_mul=1.
- MUL accepted in cycle N, MUL_LATENCY>1:
  - Cycle N+1: ex_start=1, ex_sel_mul=1; enter MUL_BUSY with cnt=MUL_LATENCY-1.
  - cnt decrements every cycle in MUL_BUSY.
  - busy=1 and hazard_valid=1 (hazard_rd=dec_rd) for cycles N+1 … N+MUL_LATENCY.
  - In the cycle where cnt==0: ex_done=1 and dec_ready=1.
  - A new op accepted in that cycle issues the next cycle; otherwise return to IDLE.
- ex_start and ex_done are single-cycle pulses. aluop/ex_rd/ex_sel_mul change only on ex_start.
- Counter width: $clog2(MUL_LATENCY+1). No wrap; cnt saturates at 0.
- flush (synchronous, highest priority after reset):
  - Next cycle: state IDLE; ex_done, busy and hazard_valid all 0; no ex_done for the squashed op.
  - dec_ready=0 during the flush cycle, so nothing is accepted.
  - A flush coinciding with the cnt==0 cycle still suppresses nothing already pulsed that cycle; it only clears state.
- Unknown opcode: the instruction is accepted and consumed as a NOP: no ex_start, no ex_done, held outputs unchanged, state unchanged.
- Reset mid-MUL: the multiplier result is discarded. The controller is ready (dec_ready=1) in the first cycle after deassertion.

Optional Feature:
ALU_ISSUE_ILLEGAL_EN
- Defined:
  - Adds output illegal_op (1 bit, reset 0).
  - An accepted unknown opcode pulses illegal_op for one cycle at N+1.
  - Emits `WARNING with the opcode value.
  - Still no ex_start or ex_done.
- Undefined: the port is absent; unknown opcodes are silently consumed as NOP.

Test Plan:
1. ADD rd=3 accepted cycle 0, SUB rd=4 accepted cycle 1 → cycle 1: ex_start=ex_done=1, aluop=ALUOP_ADD, ex_rd=3; cycle 2: aluop=ALUOP_SUB, ex_rd=4.
2. MUL rd=7 accepted cycle 0 (MUL_LATENCY=5) → ex_start cycle 1; busy/hazard_valid=1 with hazard_rd=7 cycles 1–5; dec_ready=0 cycles 1–4; ex_done=1 cycle 5 only.
3. MUL at cycle 0, then LDW rd=2 with dec_valid held from cycle 1 → LDW accepted cycle 5, ex_start with aluop=ALUOP_LDW cycle 6, ex_sel_mul=0.
4. MUL at cycle 0, flush=1 in cycle 3 → dec_ready=0 cycle 3; cycle 4: busy=0, hazard_valid=0; ex_done never asserted.
5. MUL at cycle 0, reset asserted mid-cycle 2 → all outputs 0 immediately; after release, ADD is accepted in the first cycle.
6. dec_opcode=0xFF accepted → no ex_start/ex_done and aluop unchanged; with ALU_ISSUE_ILLEGAL_EN, illegal_op=1 for exactly one cycle.
